z80_mem_arbiter: RTL and testbench

Shares one synchronous single-port RAM between the z80 core and a video fetch requester.
The z80 core has no wait input, so the block stalls it by controlling the core's clock enable (cpu_ce), which is consumed at top level.
A 3-state scheduler interleaves CPU accesses with bounded video read bursts, so neither side starves.
Sits between z80 (address/we/o_data/i_data) and the RAM, alongside the video scanout unit.

---
 rtl/z80_mem_arbiter.sv | 109 ++++++++++
 tb/tb_z80_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/z80_mem_arbiter.sv
// z80_mem_arbiter
//   Shares one synchronous single-port RAM (1-cycle read latency) between the
//   z80 core and a video fetch requester. The core has no wait input, so it is
//   stalled through its clock enable. A three-state scheduler (CPU address
//   phase, CPU data phase, video grant) interleaves one CPU access with up to
//   VID_BURST video reads, so neither side starves.
//
// Ports
//   clock, reset            : system clock, async active-high reset
//   cpu_address/we/o_data   : z80 bus request
//   cpu_i_data              : read data to z80 (held stable outside data phase)
//   cpu_ce                  : z80 clock enable
//   vid_req/vid_address     : video read request (level) and address
//   vid_gnt                 : combinational, video access issued this cycle
//   vid_ack/vid_data        : video read data valid one cycle after its grant
//   mem_address/we/wdata    : RAM request
//   mem_rdata               : RAM read data, one cycle after address
module z80_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int VID_BURST = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_o_data,
    output logic [7:0]        cpu_i_data,
    output logic              cpu_ce,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_address,
    output logic              vid_gnt,
    output logic              vid_ack,
    output logic [7:0]        vid_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int CNT_W = (VID_BURST > 1) ? $clog2(VID_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VID_BURST - 1);

    typedef enum logic [1:0] {
        S_CPU_A = 2'd0,
        S_CPU_D = 2'd1,
        S_VID   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       hold_q, hold_d;
    logic             vid_ack_q, vid_ack_d;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_CPU_A;
            cnt_q     <= '0;
            hold_q    <= '0;
            vid_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            vid_ack_q <= vid_ack_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = S_CPU_A;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        vid_ack_d = vid_gnt;
        unique case (state_q)
            S_CPU_A: state_d = S_CPU_D;
            S_CPU_D: begin
                // Capture the read so the core sees stable data while stalled.
                hold_d = mem_rdata;
                if (vid_req) begin
                    state_d = S_VID;
                    cnt_d   = '0;
                end
            end
            S_VID: begin
                // Counter only advances while the burst continues, so it never
                // exceeds VID_BURST-1 and needs no extra bit.
                if (vid_req && (cnt_q < CNT_LAST)) begin
                    state_d = S_VID;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = S_CPU_A;
        endcase
    end

    // Output logic
    always_comb begin
        mem_address = (state_q == S_VID) ? vid_address : cpu_address;
        mem_wdata   = cpu_o_data;
        mem_we      = (state_q == S_CPU_A) && cpu_we && !reset;
        cpu_ce      = (state_q == S_CPU_D) && !reset;
        vid_gnt     = (state_q == S_VID) && vid_req && !reset;
        cpu_i_data  = (state_q == S_CPU_D) ? mem_rdata : hold_q;
        vid_ack     = vid_ack_q;
        vid_data    = mem_rdata;
    end

endmodule

// File: tb/tb_z80_mem_arbiter.sv
module tb_z80_mem_arbiter;

    localparam int ADDR_W    = 16;
    localparam int VID_BURST = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] cpu_address = '0;
    logic              cpu_we = 1'b0;
    logic [7:0]        cpu_o_data = '0;
    logic [7:0]        cpu_i_data;
    logic              cpu_ce;
    logic              vid_req = 1'b0;
    logic [ADDR_W-1:0] vid_address = '0;
    logic              vid_gnt;
    logic              vid_ack;
    logic [7:0]        vid_data;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = '0;

    z80_mem_arbiter #(.ADDR_W(ADDR_W), .VID_BURST(VID_BURST)) dut (
        .clock(clock), .reset(reset),
        .cpu_address(cpu_address), .cpu_we(cpu_we), .cpu_o_data(cpu_o_data),
        .cpu_i_data(cpu_i_data), .cpu_ce(cpu_ce),
        .vid_req(vid_req), .vid_address(vid_address), .vid_gnt(vid_gnt),
        .vid_ack(vid_ack), .vid_data(vid_data),
        .mem_address(mem_address), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Environment RAM: synchronous, read-before-write, 1-cycle latency.
    logic [7:0] ram [0:65535];
    always @(posedge clock) begin
        if (mem_we) ram[mem_address] <= mem_wdata;
        mem_rdata <= ram[mem_address];
    end

    // Reference model: which slot the memory belongs to this cycle, how many
    // video slots the current burst has used, plus the expected memory image.
    logic [7:0] ref_mem [0:65535];
    byte        slot;
    int         vrun;
    logic [7:0] hold, rd_exp, ack_data;
    logic       ack_exp;
    logic       was_ce, was_gnt;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        slot = "A"; vrun = 0; hold = 8'h00; rd_exp = 8'h00;
        ack_exp = 1'b0; ack_data = 8'h00; was_ce = 1'b0; was_gnt = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, advance the model, cross the edge.
    task automatic step();
        logic gnt_e;
        @(negedge clock); #1;
        gnt_e = (slot == "V") && vid_req;
        chk("cpu_ce", cpu_ce, slot == "D");
        chk("vid_gnt", vid_gnt, gnt_e);
        chk("mem_we", mem_we, (slot == "A") && cpu_we);
        if ((slot == "A") && cpu_we) chk("mem_wdata", mem_wdata, cpu_o_data);
        chk("mem_address", mem_address, (slot == "V") ? vid_address : cpu_address);
        chk("cpu_i_data", cpu_i_data, (slot == "D") ? rd_exp : hold);
        chk("vid_ack", vid_ack, ack_exp);
        if (ack_exp) chk("vid_data", vid_data, ack_data);

        ack_exp  = gnt_e;
        ack_data = ref_mem[vid_address];
        was_ce   = (slot == "D");
        was_gnt  = gnt_e;
        case (slot)
            "A": begin
                rd_exp = ref_mem[cpu_address];
                if (cpu_we) ref_mem[cpu_address] = cpu_o_data;
                slot = "D";
            end
            "D": begin
                hold = rd_exp;
                vrun = 0;
                slot = vid_req ? "V" : "A";
            end
            default: begin
                vrun++;
                slot = (vid_req && vrun < VID_BURST) ? "V" : "A";
            end
        endcase
        @(posedge clock); #1;
    endtask

    task automatic vid_follow();
        if (was_gnt) vid_address = vid_address + 1'b1;
    endtask

    initial begin
        bit dropped;
        int acks;
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[0] = 8'h3E; ref_mem[0] = 8'h3E;
        model_reset();

        // Reset state, with requests active to prove they are masked.
        reset = 1'b1; cpu_we = 1'b1; vid_req = 1'b1; cpu_address = 16'h1234;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        chk("rst_cpu_ce", cpu_ce, 1'b0);
        chk("rst_vid_gnt", vid_gnt, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_vid_ack", vid_ack, 1'b0);
        chk("rst_cpu_i_data", cpu_i_data, 8'h00);
        chk("rst_mem_address", mem_address, 16'h1234);
        cpu_we = 1'b0; vid_req = 1'b0; cpu_address = 16'h0000;
        @(posedge clock); #1;
        reset = 1'b0;

        // CPU only, opcode fetch from 0x0000.
        repeat (6) step();

        // CPU write 0x55 to 0x4000, held through the data phase.
        cpu_address = 16'h4000; cpu_we = 1'b1; cpu_o_data = 8'h55;
        step();
        step();
        chk("ram_write", ram[16'h4000], 8'h55);
        cpu_we = 1'b0; cpu_address = 16'h0000;

        // Continuous video from 0x5800; count acks over three full periods.
        vid_req = 1'b1; vid_address = 16'h5800;
        acks = 0;
        repeat (3 * (VID_BURST + 2)) begin
            step(); vid_follow();
            if (ack_exp) acks++;
        end
        chk("burst_acks", acks, 3 * VID_BURST);

        // Drop vid_req after 2 grants of a burst.
        dropped = 1'b0;
        for (int n = 0; n < 20 && !dropped; n++) begin
            step(); vid_follow();
            if (slot == "V" && vrun == 2) begin vid_req = 1'b0; dropped = 1'b1; end
        end
        chk("drop_reached", dropped, 1'b1);
        repeat (4) begin step(); vid_follow(); end

        // vid_req rises in the address phase of a CPU write.
        for (int n = 0; n < 4 && slot != "A"; n++) step();
        vid_req = 1'b1; cpu_we = 1'b1; cpu_address = 16'h4001; cpu_o_data = 8'hA7;
        step(); step();
        cpu_we = 1'b0;
        chk("wr_before_vid", ram[16'h4001], 8'hA7);
        repeat (3) begin step(); vid_follow(); end

        // Reset in the 2nd video slot of a burst.
        dropped = 1'b0;
        for (int n = 0; n < 20 && !dropped; n++) begin
            step(); vid_follow();
            if (slot == "V" && vrun == 1) dropped = 1'b1;
        end
        chk("mid_burst_reached", dropped, 1'b1);
        cpu_we = 1'b1;
        @(negedge clock); #2;
        reset = 1'b1; #1;
        chk("mid_rst_vid_ack", vid_ack, 1'b0);
        chk("mid_rst_mem_we", mem_we, 1'b0);
        chk("mid_rst_cpu_ce", cpu_ce, 1'b0);
        chk("mid_rst_vid_gnt", vid_gnt, 1'b0);
        chk("mid_rst_addr", mem_address, cpu_address);
        model_reset();
        @(posedge clock); #1;
        reset = 1'b0; cpu_we = 1'b0; vid_req = 1'b0;
        repeat (6) step();

        // Randomized traffic: core changes its request after each enabled
        // edge, video requester toggles its level request now and then.
        for (int n = 0; n < 600; n++) begin
            if (was_ce) begin
                cpu_address = 16'($urandom_range(0, 63));
                cpu_we      = ($urandom_range(0, 3) == 0);
                cpu_o_data  = 8'($urandom);
            end
            vid_follow();
            if ($urandom_range(0, 5) == 0) vid_req = ~vid_req;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
